// File: rtl/mul_cell_pipe.sv
// Pipelined integer multiply cell (MUL / MULXUU / MULXSU / MULXSS) with
// valid/ready flow control, a per-operation tag and a synchronous flush.
module mul_cell_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] A_mul_src1,
  input  logic [DATA_W-1:0] A_mul_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A_mul_cell_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int PW  = 2 * DATA_W;
  localparam int HW  = DATA_W / 2;
  localparam int HIW = DATA_W + 1 - HW;

  logic [STAGES-1:0] valid_q, valid_d, adv;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic [DATA_W-1:0] res_q, res_d;
  logic              take;

  logic [DATA_W:0]   a_ext, b_ext;
  logic [PW-1:0]     a_wide, blo_wide, bhi_wide, pp_lo, pp_hi;

  function automatic logic [DATA_W-1:0] pick(input logic [1:0] mode, input logic [PW-1:0] p);
    return (mode == 2'd0) ? p[DATA_W-1:0] : p[PW-1:DATA_W];
  endfunction

  // Only product bits below 2*DATA_W are ever selected, so partials are kept modulo 2^(2*DATA_W).
  always_comb begin
    a_ext    = {in_mode[1] & A_mul_src1[DATA_W-1], A_mul_src1};
    b_ext    = {(in_mode == 2'd3) & A_mul_src2[DATA_W-1], A_mul_src2};
    a_wide   = {{(DATA_W-1){a_ext[DATA_W]}}, a_ext};
    blo_wide = {{(PW-HW){1'b0}}, b_ext[HW-1:0]};
    bhi_wide = {{(PW-HIW){b_ext[DATA_W]}}, b_ext[DATA_W:HW]};
    pp_lo    = a_wide * blo_wide;
    pp_hi    = (a_wide * bhi_wide) << HW;
  end

  always_comb begin
    logic chain;
    chain = ~valid_q[STAGES-1] | out_ready;
    adv[STAGES-1] = chain;
    for (int k = STAGES - 2; k >= 0; k--) begin
      chain  = ~valid_q[k] | chain;
      adv[k] = chain;
    end
  end

  assign in_ready = adv[0] & ~flush;
  assign take     = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) tag_d[k] = tag_q[k];
    if (adv[0]) begin
      valid_d[0] = take;
      if (take) tag_d[0] = in_tag;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        valid_d[k] = valid_q[k-1];
        tag_d[k]   = tag_q[k-1];
      end
    end
    if (flush) valid_d = '0;
  end

  generate
    if (STAGES == 1) begin : g_single
      always_comb begin
        res_d = res_q;
        if (take) res_d = pick(in_mode, pp_lo + pp_hi);
      end
    end else begin : g_multi
      localparam int P = STAGES - 1;
      logic [1:0]    mode_q [P];
      logic [1:0]    mode_d [P];
      logic [PW-1:0] lo_q [P];
      logic [PW-1:0] lo_d [P];
      logic [PW-1:0] hi_q [P];
      logic [PW-1:0] hi_d [P];

      // Partials travel with their mode; the final add and half-select happen entering the last stage.
      always_comb begin
        for (int k = 0; k < P; k++) begin
          mode_d[k] = mode_q[k];
          lo_d[k]   = lo_q[k];
          hi_d[k]   = hi_q[k];
        end
        if (take) begin
          mode_d[0] = in_mode;
          lo_d[0]   = pp_lo;
          hi_d[0]   = pp_hi;
        end
        for (int k = 1; k < P; k++) begin
          if (adv[k] & valid_q[k-1]) begin
            mode_d[k] = mode_q[k-1];
            lo_d[k]   = lo_q[k-1];
            hi_d[k]   = hi_q[k-1];
          end
        end
        res_d = res_q;
        if (adv[STAGES-1] & valid_q[STAGES-2])
          res_d = pick(mode_q[P-1], lo_q[P-1] + hi_q[P-1]);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < P; k++) begin
            mode_q[k] <= '0;
            lo_q[k]   <= '0;
            hi_q[k]   <= '0;
          end
        end else begin
          for (int k = 0; k < P; k++) begin
            mode_q[k] <= mode_d[k];
            lo_q[k]   <= lo_d[k];
            hi_q[k]   <= hi_d[k];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      res_q   <= '0;
      for (int k = 0; k < STAGES; k++) tag_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      for (int k = 0; k < STAGES; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign out_valid         = valid_q[STAGES-1];
  assign A_mul_cell_result = res_q;
  assign out_tag           = tag_q[STAGES-1];
  assign busy              = |valid_q;

endmodule

// File: tb/tb_mul_cell_pipe.sv
// Self-checking bench for mul_cell_pipe: directed vector table on a 32-bit/2-stage
// cell plus backpressure, flush, async reset and a 16-bit sweep over STAGES 1/3/4.
module tb_mul_cell_pipe;

   localparam int W  = 32;
   localparam int S  = 2;
   localparam int TW = 5;

   logic          clk = 1'b0;
   logic          reset, flush, inValid, inReady, outValid, outReady, busy;
   logic [1:0]    inMode;
   logic [W-1:0]  src1, src2, result;
   logic [TW-1:0] inTag, outTag;

   logic          swValid, swOutReady, swFlush;
   logic [1:0]    swMode;
   logic [15:0]   swA, swB;
   logic [TW-1:0] swTag;
   logic          swInReady [3];
   logic          swOutValid [3];
   logic          swBusy [3];
   logic [15:0]   swRes [3];
   logic [TW-1:0] swOutTag [3];

   typedef struct {
      logic [1:0]    mode;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [TW-1:0] tag;
      logic [W-1:0]  exp;
   } vec_t;

   typedef struct {
      logic [W-1:0]  res;
      logic [TW-1:0] tag;
      int            cyc;
   } exp_t;

   vec_t          vecs [13];
   exp_t          expQ [$];
   exp_t          e;
   int            checks = 0;
   int            passed = 0;
   int            cyc = 0;
   int            popped = 0;
   bit            latCheck, stallHeld, sawBlocked, sweepOn;
   logic [W-1:0]  curExp, stallRes;
   logic [TW-1:0] stallTag;
   int            lat [3] = '{1, 3, 4};
   bit            hv [16];
   logic [15:0]   hres [16];
   logic [TW-1:0] htag [16];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mul_cell_pipe #(.DATA_W(W), .STAGES(S), .TAG_W(TW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(inReady),
      .in_mode(inMode), .A_mul_src1(src1), .A_mul_src2(src2), .in_tag(inTag),
      .out_valid(outValid), .out_ready(outReady), .A_mul_cell_result(result),
      .out_tag(outTag), .busy(busy));

   mul_cell_pipe #(.DATA_W(16), .STAGES(1), .TAG_W(TW)) sw1 (
      .clk(clk), .reset(reset), .flush(swFlush), .in_valid(swValid), .in_ready(swInReady[0]),
      .in_mode(swMode), .A_mul_src1(swA), .A_mul_src2(swB), .in_tag(swTag),
      .out_valid(swOutValid[0]), .out_ready(swOutReady), .A_mul_cell_result(swRes[0]),
      .out_tag(swOutTag[0]), .busy(swBusy[0]));

   mul_cell_pipe #(.DATA_W(16), .STAGES(3), .TAG_W(TW)) sw3 (
      .clk(clk), .reset(reset), .flush(swFlush), .in_valid(swValid), .in_ready(swInReady[1]),
      .in_mode(swMode), .A_mul_src1(swA), .A_mul_src2(swB), .in_tag(swTag),
      .out_valid(swOutValid[1]), .out_ready(swOutReady), .A_mul_cell_result(swRes[1]),
      .out_tag(swOutTag[1]), .busy(swBusy[1]));

   mul_cell_pipe #(.DATA_W(16), .STAGES(4), .TAG_W(TW)) sw4 (
      .clk(clk), .reset(reset), .flush(swFlush), .in_valid(swValid), .in_ready(swInReady[2]),
      .in_mode(swMode), .A_mul_src1(swA), .A_mul_src2(swB), .in_tag(swTag),
      .out_valid(swOutValid[2]), .out_ready(swOutReady), .A_mul_cell_result(swRes[2]),
      .out_tag(swOutTag[2]), .busy(swBusy[2]));

   // Reference multiply: true signed values of both operands, full product, then half select.
   function automatic logic [31:0] refMul(input int w, input logic [1:0] mode,
                                          input logic [31:0] a, input logic [31:0] b);
      logic signed [67:0] ea, eb, p, sh;
      logic [67:0]        mask, tmp;
      ea = $signed({36'd0, a});
      eb = $signed({36'd0, b});
      if (mode[1] && a[w-1]) ea = ea - (68'sd1 <<< w);
      if (mode == 2'd3 && b[w-1]) eb = eb - (68'sd1 <<< w);
      p    = ea * eb;
      sh   = (mode == 2'd0) ? p : (p >>> w);
      mask = (68'd1 << w) - 68'd1;
      tmp  = sh & mask;
      return tmp[31:0];
   endfunction

   // Every comparison in the bench funnels through here so the counters stay honest.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Drives one cycle's worth of inputs just after the rising edge.
   task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [TW-1:0] t,
                                input logic [W-1:0] x);
      @(posedge clk);
      #1;
      inValid = v;
      inMode  = m;
      src1    = a;
      src2    = b;
      inTag   = t;
      curExp  = x;
   endtask

   // Offers an operation and holds it until the cell takes it.
   task automatic issueOp(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] t, input logic [W-1:0] x);
      int n;
      applyStimulus(1'b1, m, a, b, t, x);
      @(negedge clk);
      n = 0;
      while (!inReady && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) checkOutput("in_ready timeout", {63'd0, inReady}, 64'd1);
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 40) begin
         @(posedge clk);
         #2;
         n++;
      end
      checkOutput(name, expQ.size(), 0);
   endtask

   // Scoreboard for the main cell: in-order results, tags, latency and hold-while-stalled.
   always @(negedge clk) begin
      if (reset) begin
         stallHeld = 1'b0;
      end else begin
         if (stallHeld && outValid) begin
            checkOutput("stall result", result, stallRes);
            checkOutput("stall tag", outTag, stallTag);
         end
         if (outValid && outReady) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious out_valid", {63'd0, outValid}, 64'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput($sformatf("result tag%0d", e.tag), result, e.res);
               checkOutput($sformatf("out_tag tag%0d", e.tag), outTag, e.tag);
               if (latCheck) checkOutput($sformatf("latency tag%0d", e.tag), cyc - e.cyc, S);
               popped++;
            end
         end
         if (!outReady && busy && inValid && !inReady) sawBlocked = 1'b1;
         stallHeld = outValid && !outReady;
         stallRes  = result;
         stallTag  = outTag;
         if (inValid && inReady) expQ.push_back('{curExp, inTag, cyc});
      end
   end

   // Sweep checker: each cell's output must equal what was offered exactly STAGES cycles earlier.
   always @(negedge clk) begin
      logic [31:0] r;
      int          idx;
      if (sweepOn && !reset) begin
         r = refMul(16, swMode, {16'd0, swA}, {16'd0, swB});
         hv[cyc % 16]   = swValid;
         hres[cyc % 16] = r[15:0];
         htag[cyc % 16] = swTag;
         for (int k = 0; k < 3; k++) begin
            idx = (cyc - lat[k]) % 16;
            checkOutput($sformatf("sweep S%0d valid", lat[k]), {63'd0, swOutValid[k]}, {63'd0, hv[idx]});
            if (hv[idx]) begin
               checkOutput($sformatf("sweep S%0d result", lat[k]), swRes[k], hres[idx]);
               checkOutput($sformatf("sweep S%0d tag", lat[k]), swOutTag[k], htag[idx]);
               checkOutput($sformatf("sweep S%0d busy", lat[k]), {63'd0, swBusy[k]}, 64'd1);
            end
            if (swValid) checkOutput($sformatf("sweep S%0d in_ready", lat[k]), {63'd0, swInReady[k]}, 64'd1);
         end
      end
   end

   initial begin
      int p0;
      vecs[0]  = '{2'd0, 32'h0000FFFF, 32'h0000FFFF, 5'd1,  32'hFFFE0001};
      vecs[1]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE};
      vecs[2]  = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF};
      vecs[3]  = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000000};
      vecs[4]  = '{2'd3, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000};
      vecs[5]  = '{2'd0, 32'h00000007, 32'h00000006, 5'd6,  32'h0000002A};
      vecs[6]  = '{2'd1, 32'h80000000, 32'h00000002, 5'd7,  32'h00000001};
      vecs[7]  = '{2'd2, 32'h80000000, 32'h00000002, 5'd8,  32'hFFFFFFFF};
      vecs[8]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'h00000001};
      vecs[9]  = '{2'd3, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd10, 32'h3FFFFFFF};
      vecs[10] = '{2'd2, 32'hFFFFFFFF, 32'h80000000, 5'd11, 32'hFFFFFFFF};
      vecs[11] = '{2'd3, 32'h80000000, 32'h7FFFFFFF, 5'd12, 32'hC0000000};
      vecs[12] = '{2'd1, 32'h00000000, 32'hFFFFFFFF, 5'd13, 32'h00000000};

      reset = 1'b1; flush = 1'b0; inValid = 1'b0; inMode = 2'd0; src1 = '0; src2 = '0;
      inTag = '0; outReady = 1'b1; curExp = '0; latCheck = 1'b1; sawBlocked = 1'b0;
      swValid = 1'b0; swOutReady = 1'b1; swFlush = 1'b0; swMode = 2'd0; swA = '0; swB = '0;
      swTag = '0; sweepOn = 1'b0;

      #3;
      checkOutput("reset out_valid", {63'd0, outValid}, 64'd0);
      checkOutput("reset busy", {63'd0, busy}, 64'd0);
      checkOutput("reset result", result, 64'd0);
      checkOutput("reset out_tag", outTag, 64'd0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;

      $display("[TB] directed vector table");
      for (int i = 0; i < 13; i++)
         issueOp(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);
      applyStimulus(1'b0, 2'd0, '0, '0, '0, '0);
      waitDrain("table drain");

      $display("[TB] backpressure stream");
      latCheck = 1'b0;
      p0 = popped;
      fork
         begin
            for (int i = 0; i < 6; i++)
               issueOp(2'd0, W'(i + 1), W'(i + 3), TW'(16 + i), W'((i + 1) * (i + 3)));
            applyStimulus(1'b0, 2'd0, '0, '0, '0, '0);
         end
         begin
            for (int c = 0; c < 12; c++) begin
               @(posedge clk);
               #1 outReady = !(c >= 3 && c <= 8);
            end
         end
      join
      waitDrain("backpressure drain");
      checkOutput("backpressure count", popped - p0, 6);
      checkOutput("backpressure in_ready low", {63'd0, sawBlocked}, 64'd1);
      latCheck = 1'b1;

      $display("[TB] flush with two in flight");
      outReady = 1'b0;
      issueOp(2'd0, 32'd3, 32'd5, 5'd20, 32'd15);
      issueOp(2'd1, 32'hFFFFFFFF, 32'd2, 5'd21, 32'd1);
      @(posedge clk);
      #1;
      flush = 1'b1; inValid = 1'b1; inMode = 2'd0; src1 = 32'd9; src2 = 32'd9; inTag = 5'd22;
      @(negedge clk);
      checkOutput("flush in_ready", {63'd0, inReady}, 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
      expQ.delete();
      checkOutput("flush busy", {63'd0, busy}, 64'd0);
      checkOutput("flush out_valid", {63'd0, outValid}, 64'd0);
      repeat (4) @(posedge clk);
      issueOp(2'd3, 32'hFFFFFFFE, 32'd3, 5'd23, 32'hFFFFFFFF);
      applyStimulus(1'b0, 2'd0, '0, '0, '0, '0);
      waitDrain("post-flush drain");

      $display("[TB] async reset with full pipe");
      outReady = 1'b0;
      issueOp(2'd0, 32'd11, 32'd13, 5'd24, 32'd143);
      issueOp(2'd0, 32'd17, 32'd19, 5'd25, 32'd323);
      applyStimulus(1'b0, 2'd0, '0, '0, '0, '0);
      #1;
      checkOutput("pre-reset busy", {63'd0, busy}, 64'd1);
      checkOutput("pre-reset out_valid", {63'd0, outValid}, 64'd1);
      #1 reset = 1'b1;
      #1;
      checkOutput("async reset out_valid", {63'd0, outValid}, 64'd0);
      checkOutput("async reset busy", {63'd0, busy}, 64'd0);
      checkOutput("async reset result", result, 64'd0);
      expQ.delete();
      @(posedge clk);
      #3 reset = 1'b0;
      outReady = 1'b1;
      issueOp(2'd1, 32'h12345678, 32'h00010000, 5'd26, 32'h00001234);
      applyStimulus(1'b0, 2'd0, '0, '0, '0, '0);
      waitDrain("post-reset drain");

      $display("[TB] 16-bit sweep, STAGES 1/3/4");
      for (int i = 0; i < 16; i++) hv[i] = 1'b0;
      @(posedge clk);
      #1 sweepOn = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         swValid = ($urandom_range(0, 7) != 0);
         swMode  = 2'($urandom_range(0, 3));
         swA     = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
         swB     = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         swTag   = TW'(i);
      end
      @(posedge clk);
      #1 swValid = 1'b0;
      repeat (6) @(posedge clk);
      #1 sweepOn = 1'b0;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
